// File: rtl/division_seq.sv
// division_seq: sequential signed fixed-point divider, Result = A / B.
// Restoring division producing one quotient bit per clock with a fixed
// latency of WIDTH+FRAC+1 edges after the accepting start edge.
// Out-of-range and divide-by-zero results saturate to the multiplier's
// encoding (+max = 0x7FFF_FFFF, -max = 0x8000_0001 for WIDTH=32).
//
// Ports:
//   clk         - clock, all logic on rising edge
//   rst         - synchronous active-high reset (aborts an operation)
//   start       - request, sampled only while idle
//   A           - dividend, signed Q(WIDTH-FRAC).FRAC
//   B           - divisor,  signed Q(WIDTH-FRAC).FRAC
//   Result      - quotient, held until the next completion
//   busy        - operation in flight
//   done        - single-cycle completion pulse
//   div_by_zero - B was zero for the last completed operation
module division_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW);

    localparam logic [WIDTH-1:0] POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_SAT = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX
    } state_t;

    state_t state, next_state;

    // quo starts as the shifted dividend; each step shifts a dividend bit
    // out of the top and a quotient bit into the bottom.
    logic [QW-1:0]  quo;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] b_mag;
    logic [CW-1:0]  cnt;
    logic           neg_q;
    logic           a_neg;
    logic           b_zero;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             step_ge;
    logic [WIDTH-1:0] fix_result;

    // Unsigned WIDTH-bit negation maps 0x80..0 to 2^(WIDTH-1) correctly.
    assign a_abs = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;

    // Remainder stays below |B| <= 2^(WIDTH-1), so the shifted value
    // always fits in WIDTH+1 bits.
    always_comb begin
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, quo[QW-1]};
        step_ge   = (rem_shift >= b_mag);
        rem_sub   = rem_shift - b_mag;
    end

    always_comb begin
        fix_result = '0;
        if (b_zero)
            fix_result = a_neg ? NEG_SAT : POS_SAT;
        else if (|quo[QW-1:WIDTH-1])
            fix_result = neg_q ? NEG_SAT : POS_SAT;
        else
            fix_result = neg_q ? (~quo[WIDTH-1:0] + 1'b1) : quo[WIDTH-1:0];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DIVIDE;
            DIVIDE:  if (cnt == CW'(QW - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            quo         <= '0;
            rem         <= '0;
            b_mag       <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            a_neg       <= 1'b0;
            b_zero      <= 1'b0;
            Result      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo    <= {a_abs, {FRAC{1'b0}}};
                        rem    <= '0;
                        b_mag  <= {1'b0, b_abs};
                        cnt    <= '0;
                        neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        a_neg  <= A[WIDTH-1];
                        b_zero <= (B == '0);
                    end
                end
                DIVIDE: begin
                    quo <= (quo << 1) | {{(QW-1){1'b0}}, step_ge};
                    rem <= step_ge ? rem_sub : rem_shift;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    Result      <= fix_result;
                    div_by_zero <= b_zero;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_seq.sv
module tb_division_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    division_seq #(.WIDTH(32), .FRAC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Result      (Result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_z, input string tag);
        int n;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        check({tag, "_lat"}, n, 32'd49);
        check({tag, "_res"}, Result, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
        check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_done1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, Result, exp_r);
    endtask

    initial begin
        int n;
        int dc;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(32'h0004E000, 32'h00018000, 32'h00034000, 1'b0, "basic");
        run_op(32'hFE8D3800, 32'h00235000, 32'hFFF58000, 1'b0, "mixed");
        run_op(32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, "neg_third");
        run_op(32'h00010000, 32'h00030000, 32'h00005555, 1'b0, "third");
        run_op(32'hFFFF0000, 32'hFFFD0000, 32'h00005555, 1'b0, "negneg");
        run_op(32'h75300000, 32'h00004000, 32'h7FFFFFFF, 1'b0, "sat_pos");
        run_op(32'h8AD00000, 32'h00004000, 32'h80000001, 1'b0, "sat_neg");
        run_op(32'h80000000, 32'h00010000, 32'h80000001, 1'b0, "min_by_one");
        run_op(32'h00018000, 32'h00000000, 32'h7FFFFFFF, 1'b1, "dbz_pos");
        run_op(32'hFFFF0000, 32'h00000000, 32'h80000001, 1'b1, "dbz_neg");
        run_op(32'h00000000, 32'h00018000, 32'h00000000, 1'b0, "zero_num");

        // start pulses while busy must be ignored
        dc = done_cnt;
        @(negedge clk);
        A = 32'h0004E000; B = 32'h00018000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        A = 32'h00010000; B = 32'h00030000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        wait_done(n);
        check("ign_lat", n, 32'd37);
        check("ign_res", Result, 32'h00034000);
        repeat (60) @(posedge clk);
        #1;
        check("ign_done_count", done_cnt - dc, 32'd1);
        check("ign_idle", {31'd0, busy}, 32'd0);

        // start held high through the done cycle launches the next op at once
        @(negedge clk);
        A = 32'h00010000; B = 32'h00030000; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        check("b2b_lat1", n, 32'd49);
        check("b2b_res1", Result, 32'h00005555);
        A = 32'h0004E000; B = 32'h00018000;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b_lat2", n, 32'd49);
        check("b2b_res2", Result, 32'h00034000);

        // reset at edge k+20 aborts with no done pulse
        @(negedge clk);
        A = 32'h75300000; B = 32'h00004000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = done_cnt;
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_result", Result, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - dc, 32'd0);
        check("rst_mid_result_held", Result, 32'd0);
        run_op(32'hFE8D3800, 32'h00235000, 32'hFFF58000, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
